i2s_mic_rx: RTL

//   I2S master receiver for one MEMS microphone (INMP441-class), upstream of the noise-cancel datapath.

---
 rtl/i2s_mic_rx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/i2s_mic_rx.sv
// rtl/i2s_mic_rx.sv - I2S master receiver for one MEMS microphone slot
//
// Generates the I2S bit clock (mic_sck) and word select (mic_ws) from
// sys_clk. It deserialises the slot chosen by CHAN_SEL and presents each
// word as a signed DATA_W-bit sample on a valid/ready handshake. After every
// enable, the first STARTUP_FRAMES frames are discarded while the
// microphone settles.
//
// Ports:
//   sys_clk       in   system clock
//   sys_rst       in   synchronous reset, active-high
//   en            in   1 = run interface, 0 = stop and clear
//   mic_sd        in   serial data from microphone
//   mic_sck       out  bit clock to microphone
//   mic_ws        out  word select to microphone
//   mic_chan      out  microphone L/R strap, constant CHAN_SEL
//   sample        out  captured sample, two's complement
//   sample_valid  out  sample holds a new, unconsumed value
//   sample_ready  in   consumer accepts sample when high with sample_valid
//   overrun       out  sticky: a sample completed while the previous one was unconsumed

module i2s_mic_rx #(
   parameter int CLK_DIV        = 8,
   parameter int DATA_W         = 24,
   parameter int CHAN_SEL       = 0,
   parameter int STARTUP_FRAMES = 256
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              en,
   input  logic              mic_sd,
   output logic              mic_sck,
   output logic              mic_ws,
   output logic              mic_chan,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overrun
);

   localparam int   DIV_W    = $clog2(CLK_DIV);
   localparam int   FRM_W    = $clog2(STARTUP_FRAMES + 1);
   localparam logic CHAN_BIT = CHAN_SEL[0];

   typedef enum logic [1:0] {
      ST_OFF,
      ST_WARMUP,
      ST_RUN
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [5:0]        bit_cnt;
   logic [FRM_W-1:0]  frame_cnt;
   logic [DATA_W-1:0] shift;
   logic              sample_done;

   logic              sck_tick;
   logic              sck_fall;
   logic [4:0]        slot_k;
   logic              in_slot;
   logic [5:0]        bit_nxt;
   logic [DATA_W:0]   shift_cat;

   assign mic_chan  = CHAN_BIT;
   assign sck_tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
   // Falling event: the tick on which mic_sck goes from 1 to 0
   assign sck_fall  = sck_tick && mic_sck;
   assign slot_k    = bit_cnt[4:0];
   // k = 0 is the I2S delay bit; bits past DATA_W are ignored
   assign in_slot   = (bit_cnt[5] == CHAN_BIT) && (slot_k != 5'd0) && (slot_k <= 5'(DATA_W));
   assign bit_nxt   = bit_cnt + 6'd1;
   // The extra top bit is dropped; this form also covers DATA_W = 1
   assign shift_cat = {shift, mic_sd};

   always_ff @(posedge sys_clk) begin
      if (sys_rst || !en) begin
         state        <= ST_OFF;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         frame_cnt    <= '0;
         shift        <= '0;
         sample_done  <= 1'b0;
         mic_sck      <= 1'b0;
         mic_ws       <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (state == ST_OFF) begin
         // All counters are already clear; SCK starts CLK_DIV cycles from here
         state <= ST_WARMUP;
      end else begin
         if (sck_tick) begin
            div_cnt <= '0;
            mic_sck <= ~mic_sck;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         sample_done <= 1'b0;
         if (sck_fall) begin
            bit_cnt <= bit_nxt;
            mic_ws  <= bit_nxt[5];
            if (in_slot) begin
               shift <= shift_cat[DATA_W-1:0];
               // Completions during warmup are discarded
               if (slot_k == 5'(DATA_W) && state == ST_RUN)
                  sample_done <= 1'b1;
            end
            if (state == ST_WARMUP && bit_cnt == 6'd63) begin
               if (frame_cnt == FRM_W'(STARTUP_FRAMES - 1)) begin
                  frame_cnt <= '0;
                  state     <= ST_RUN;
               end else begin
                  frame_cnt <= frame_cnt + FRM_W'(1);
               end
            end
         end

         // A load on the same edge as an accept wins, so valid stays high
         if (sample_done) begin
            if (!sample_valid || sample_ready) begin
               sample       <= shift;
               sample_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end
      end
   end

endmodule
